// File: rtl/tx_64b66b_gearbox_scrambler_if.sv
// Block input handshake for the 64b/66b TX gearbox.
//   in_valid    block present on in_header/in_payload
//   in_ready    block accepted when in_valid && in_ready
//   in_header   2-bit sync header (sent unscrambled)
//   in_payload  64-bit payload, bit 63 transmitted first
// master = block source, slave = gearbox.
interface tx_64b66b_gearbox_scrambler_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_header;
    logic [63:0] in_payload;

    modport master (output in_valid, output in_header, output in_payload, input in_ready);
    modport slave  (input in_valid, input in_header, input in_payload, output in_ready);
endinterface

// File: rtl/tx_64b66b_gearbox_scrambler.sv
// Transmit 64b/66b path: scrambles block payloads (x^58+x^39+1, self-synchronous)
// and gearboxes the 66-bit block stream to one 32-bit word per tx_clk.
// On underrun a 10GBASE-R idle block is substituted so the line never stalls.
// Ports:
//   tx_clk          transmit clock, rising edge
//   tx_rst          synchronous active-high reset
//   blk             block input handshake (slave side)
//   tx_data         32-bit word to SERDES, bit 31 transmitted first
//   idle_inserted   one-cycle pulse when an idle block was substituted
//   underrun_count  saturating count of substituted idle blocks
module tx_64b66b_gearbox_scrambler #(
    parameter bit SCRAMBLE    = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst,
    tx_64b66b_gearbox_scrambler_if.slave  blk,
    output logic [31:0]                   tx_data,
    output logic                          idle_inserted,
    output logic [COUNT_WIDTH-1:0]        underrun_count
);

    localparam logic [63:0] IDLE_PAYLOAD = 64'h1E00_0000_0000_0000;
    localparam logic [1:0]  CTRL_HEADER  = 2'b10;

    // Scramble one payload in transmit order. h[] holds scrambled bits in
    // chronological order: h[0..57] is the previous state (h[57] newest),
    // h[58+j] is the scrambled version of payload bit 63-j.
    // Returns {next_state, scrambled_payload}.
    function automatic logic [121:0] scramble(input logic [63:0] d, input logic [57:0] st);
        logic [121:0] h;
        logic [63:0]  o;
        h = '0;
        o = '0;
        h[57:0] = st;
        for (int j = 0; j < 64; j++) begin
            h[58+j] = d[63-j] ^ h[j+19] ^ h[j];
            o[63-j] = h[58+j];
        end
        return {h[121:64], o};
    endfunction

    logic [6:0]  fill;      // bits held in bits_q after this cycle's emission
    logic [96:0] bits_q;    // held bits left-aligned, MSB oldest, zeros below
    logic [57:0] scr_q;
    logic        load;
    logic [63:0] raw_payload;
    logic [63:0] scr_payload;
    logic [57:0] scr_next;
    logic [65:0] block;
    logic [96:0] merged;

    // Ready depends on registered fill only.
    assign load         = (fill < 7'd32);
    assign blk.in_ready = load;

    always_comb begin
        raw_payload = blk.in_valid ? blk.in_payload : IDLE_PAYLOAD;
        scr_payload = raw_payload;
        scr_next    = scr_q;
        if (SCRAMBLE) begin
            {scr_next, scr_payload} = scramble(raw_payload, scr_q);
        end
        block  = {(blk.in_valid ? blk.in_header : CTRL_HEADER), scr_payload};
        merged = bits_q;
        if (load) begin
            // New block lands directly below the fill held bits.
            merged = bits_q | ({block, 31'b0} >> fill);
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            fill           <= '0;
            bits_q         <= '0;
            scr_q          <= '1;
            tx_data        <= '0;
            idle_inserted  <= 1'b0;
            underrun_count <= '0;
        end else begin
            tx_data <= merged[96:65];
            bits_q  <= {merged[64:0], 32'b0};
            if (load) begin
                fill          <= fill + 7'd34;
                scr_q         <= scr_next;
                idle_inserted <= !blk.in_valid;
                if (!blk.in_valid && (underrun_count != '1)) begin
                    underrun_count <= underrun_count + 1'b1;
                end
            end else begin
                fill          <= fill - 7'd32;
                idle_inserted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_64b66b_gearbox_scrambler.sv
// Two DUTs share one stimulus: d0 raw (SCRAMBLE=0, 16-bit counter) and
// d1 scrambled (SCRAMBLE=1, 4-bit counter). A bit-serial reference model
// pushes every expected transmitted bit into a queue per DUT; the queue
// length is the expected fill, and 32 bits are popped per output word.
module tb_tx_64b66b_gearbox_scrambler;

    logic        tx_clk;
    logic        tx_rst;
    logic        v;
    logic [1:0]  hdr;
    logic [63:0] pay;

    logic [31:0] tx0, tx1;
    logic        idle0, idle1;
    logic [15:0] ucnt0;
    logic [3:0]  ucnt1;

    int total = 0;
    int bad   = 0;

    tx_64b66b_gearbox_scrambler_if blk0 ();
    tx_64b66b_gearbox_scrambler_if blk1 ();

    assign blk0.in_valid   = v;
    assign blk0.in_header  = hdr;
    assign blk0.in_payload = pay;
    assign blk1.in_valid   = v;
    assign blk1.in_header  = hdr;
    assign blk1.in_payload = pay;

    tx_64b66b_gearbox_scrambler #(.SCRAMBLE(1'b0), .COUNT_WIDTH(16)) d0 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .blk(blk0),
        .tx_data(tx0), .idle_inserted(idle0), .underrun_count(ucnt0));

    tx_64b66b_gearbox_scrambler #(.SCRAMBLE(1'b1), .COUNT_WIDTH(4)) d1 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .blk(blk1),
        .tx_data(tx1), .idle_inserted(idle1), .underrun_count(ucnt1));

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    // ---------------- reference model / scoreboard ----------------
    bit          q0[$];
    bit          q1[$];
    logic [57:0] mst;       // mst[0] = most recent scrambled bit
    int          cnt0, cnt1;
    bit          eidle0, eidle1;
    bit          started = 0;

    always @(posedge tx_clk) begin : model
        logic [63:0] d;
        logic [63:0] sp;
        logic [65:0] b0, b1;
        logic        s;
        started = 1;
        if (tx_rst) begin
            q0.delete();
            q1.delete();
            mst    = '1;
            cnt0   = 0;
            cnt1   = 0;
            eidle0 = 0;
            eidle1 = 0;
        end else if (q0.size() < 32) begin
            d = v ? pay : 64'h1E00_0000_0000_0000;
            for (int i = 63; i >= 0; i--) begin
                s     = d[i] ^ mst[38] ^ mst[57];
                sp[i] = s;
                mst   = {mst[56:0], s};
            end
            b0 = {(v ? hdr : 2'b10), d};
            b1 = {(v ? hdr : 2'b10), sp};
            for (int b = 65; b >= 0; b--) begin
                q0.push_back(b0[b]);
                q1.push_back(b1[b]);
            end
            eidle0 = !v;
            eidle1 = !v;
            if (!v) begin
                if (cnt0 < 65535) cnt0++;
                if (cnt1 < 15) cnt1++;
            end
        end else begin
            eidle0 = 0;
            eidle1 = 0;
        end
    end

    always @(negedge tx_clk) begin : monitor
        logic [31:0] e0, e1;
        if (started) begin
            e0 = '0;
            e1 = '0;
            if (q0.size() >= 32) begin
                for (int b = 31; b >= 0; b--) begin
                    e0[b] = q0.pop_front();
                    e1[b] = q1.pop_front();
                end
            end
            total += 8;
            if (tx0 !== e0) begin bad++; $display("FAIL tx_data0 got=%h exp=%h t=%0t", tx0, e0, $time); end
            if (tx1 !== e1) begin bad++; $display("FAIL tx_data1 got=%h exp=%h t=%0t", tx1, e1, $time); end
            if (idle0 !== eidle0) begin bad++; $display("FAIL idle0 got=%b exp=%b t=%0t", idle0, eidle0, $time); end
            if (idle1 !== eidle1) begin bad++; $display("FAIL idle1 got=%b exp=%b t=%0t", idle1, eidle1, $time); end
            if (ucnt0 !== 16'(cnt0)) begin bad++; $display("FAIL ucnt0 got=%0d exp=%0d t=%0t", ucnt0, cnt0, $time); end
            if (ucnt1 !== 4'(cnt1)) begin bad++; $display("FAIL ucnt1 got=%0d exp=%0d t=%0t", ucnt1, cnt1, $time); end
            if (blk0.in_ready !== (q0.size() < 32)) begin
                bad++; $display("FAIL ready0 got=%b exp=%b t=%0t", blk0.in_ready, (q0.size() < 32), $time);
            end
            if (blk1.in_ready !== (q1.size() < 32)) begin
                bad++; $display("FAIL ready1 got=%b exp=%b t=%0t", blk1.in_ready, (q1.size() < 32), $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_reset;
        tx_rst = 1'b1;
        tick();
        tx_rst = 1'b0;
    endtask

    task automatic test_reset;
        tx_rst = 1'b1;
        v = 1'b0;
        tick();
        tick();
        total += 4;
        if (tx0 !== 32'h0) begin bad++; $display("FAIL reset_tx got=%h exp=0", tx0); end
        if (idle0 !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", idle0); end
        if (ucnt0 !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ucnt0); end
        if (blk0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", blk0.in_ready); end
        tx_rst = 1'b0;
    endtask

    task automatic test_idle;
        int p0, p1;
        p0 = 0;
        p1 = 0;
        do_reset();
        v = 1'b0;
        for (int c = 0; c < 66; c++) begin
            tick();
            if (c == 0) begin
                total++;
                if (tx0 !== 32'h8780_0000) begin bad++; $display("FAIL idle_first got=%h exp=87800000", tx0); end
            end
            p0 += int'(idle0);
            p1 += int'(idle1);
        end
        total += 4;
        if (p0 != 32) begin bad++; $display("FAIL idle_pulses0 got=%0d exp=32", p0); end
        if (p1 != 32) begin bad++; $display("FAIL idle_pulses1 got=%0d exp=32", p1); end
        if (ucnt0 !== 16'd32) begin bad++; $display("FAIL idle_cnt0 got=%0d exp=32", ucnt0); end
        if (ucnt1 !== 4'hF) begin bad++; $display("FAIL idle_cnt_sat got=%0d exp=15", ucnt1); end
    endtask

    task automatic test_stream;
        int w0, w1, p;
        logic r;
        w0 = 0;
        w1 = 0;
        p  = 0;
        do_reset();
        v   = 1'b1;
        hdr = 2'b01;
        pay = 64'h0123_4567_89AB_CDEF;
        for (int c = 0; c < 66; c++) begin
            r = blk0.in_ready;
            tick();
            if (c < 33) w0 += int'(r); else w1 += int'(r);
            p += int'(idle0);
            if (r) pay = pay + 64'd1;
        end
        v = 1'b0;
        total += 3;
        if (w0 != 16) begin bad++; $display("FAIL stream_ready_w0 got=%0d exp=16", w0); end
        if (w1 != 16) begin bad++; $display("FAIL stream_ready_w1 got=%0d exp=16", w1); end
        if (p != 0) begin bad++; $display("FAIL stream_idles got=%0d exp=0", p); end
    endtask

    task automatic test_toggle;
        int idles;
        logic r;
        idles = 0;
        do_reset();
        v = 1'b0;
        for (int c = 0; c < 200; c++) begin
            r = blk0.in_ready;
            if (r && !v) idles++;
            tick();
            v = ~v;
            if (v) begin
                hdr = 2'($urandom_range(0, 3));
                pay = {$urandom(), $urandom()};
            end
        end
        v = 1'b0;
        total++;
        if (ucnt0 !== 16'(idles)) begin bad++; $display("FAIL toggle_idles got=%0d exp=%0d", ucnt0, idles); end
    endtask

    task automatic test_mid_reset;
        logic [63:0] p;
        do_reset();
        v   = 1'b1;
        hdr = 2'b10;
        pay = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();                         // one block in flight, fill = 34
        tx_rst = 1'b1;
        v      = 1'b0;
        tick();
        total += 2;
        if (tx0 !== 32'h0) begin bad++; $display("FAIL midrst_tx got=%h exp=0", tx0); end
        if (blk0.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", blk0.in_ready); end
        tx_rst = 1'b0;
        p   = 64'hA5C3_0F96_1234_5678;
        v   = 1'b1;
        hdr = 2'b01;
        pay = p;
        tick();
        v = 1'b0;
        total += 2;
        if (tx0 !== {2'b01, p[63:34]}) begin bad++; $display("FAIL midrst_first got=%h exp=%h", tx0, {2'b01, p[63:34]}); end
        if (tx1[31:30] !== 2'b01) begin bad++; $display("FAIL midrst_hdr1 got=%b exp=01", tx1[31:30]); end
        repeat (4) tick();
    endtask

    initial begin
        tx_rst = 1'b1;
        v      = 1'b0;
        hdr    = 2'b00;
        pay    = '0;
        test_reset();
        test_idle();
        test_stream();
        test_toggle();
        test_mid_reset();
        @(negedge tx_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
